pipeline_hazard_unit: RTL and testbench

- Execute-side control counterpart to the Decode->Execute pipeline register: decides when that register and the fetch/decode stages stall or flush.
- Generates operand-forwarding selects for the Execute ALU inputs.
- Keeps its own shadow pipeline of register-file tags (Rs/Rd, RegWrite, ResultSrc) through the E, M and W stages, so it needs only Decode-stage inputs plus the branch decision.
- Holds saturating event counters for load-use stalls and control flushes.

---
 rtl/pipeline_hazard_unit_pkg.sv | 16 +
 rtl/floprc.sv | 21 ++
 rtl/pipeline_hazard_unit.sv | 101 ++++++++++
 tb/tb_pipeline_hazard_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forwarding selects, result sources, register address width.
// No logic; constants only.
// Imported by the hazard unit top and any datapath that decodes its selects.
package pipeline_hazard_unit_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/floprc.sv
// Parameterised register with async active-low reset and synchronous clear.
// Latency: one clock edge from d to q.
// No backpressure; clear has priority over load.
module floprc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset to zero asynchronously; clear inserts a zero (bubble) on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= '0;
    else if (clear) q <= '0;
    else            q <= d;
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit: load-use stall, branch flush and ALU operand forwarding from shadow E/M/W register tags.
// Latency: control and forward outputs are combinational; shadow tags advance on the same edges as the datapath.
// Stalls hold F/D only; M and W always advance, so the E shadow takes a bubble on every stall or flush.
module pipeline_hazard_unit #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  LoadStallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);
  import pipeline_hazard_unit_pkg::*;

  localparam int EW = 3*REG_AW + 3;
  localparam int MW = REG_AW + 1;

  logic [REG_AW-1:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic [EW-1:0]     e_q;
  logic [MW-1:0]     m_q, w_q;
  logic              lw_stall;

  // E shadow follows the Decode->Execute register, bubbled whenever that register is flushed.
  floprc #(.W(EW)) u_e_shadow (
    .clk   (clk),
    .reset (reset),
    .clear (FlushE),
    .d     ({Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD}),
    .q     (e_q)
  );
  assign {Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE} = e_q;

  // Stages past E never stall or flush.
  floprc #(.W(MW)) u_m_shadow (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d     ({RdE, RegWriteE}),
    .q     (m_q)
  );
  assign {RdM, RegWriteM} = m_q;

  floprc #(.W(MW)) u_w_shadow (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d     ({RdM, RegWriteM}),
    .q     (w_q)
  );
  assign {RdW, RegWriteW} = w_q;

  // A load in E whose destination feeds the Decode instruction cannot be forwarded in time.
  always_comb begin
    lw_stall = RegWriteE && (ResultSrcE == RES_MEM) && (RdE != '0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Stall/flush controls; while in reset the front end is held flushed and never stalled.
  always_comb begin
    StallF = lw_stall & reset;
    StallD = lw_stall & reset;
    FlushD = PCSrcE | ~reset;
    FlushE = lw_stall | PCSrcE | ~reset;
  end

  // Forwarding selects: the younger M-stage result beats W; x0 is never forwarded.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = FWD_MEM;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = FWD_WB;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = FWD_MEM;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = FWD_WB;
  end

  // Saturating event counters; they stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LoadStallCnt <= '0;
      FlushCnt     <= '0;
    end else begin
      if (lw_stall && (LoadStallCnt != '1)) LoadStallCnt <= LoadStallCnt + CNT_W'(1);
      if (PCSrcE && (FlushCnt != '1))       FlushCnt     <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       PCSrcE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] LoadStallCnt, FlushCnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.CNT_W(4), .REG_AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .RdD          (RdD),
    .RegWriteD    (RegWriteD),
    .ResultSrcD   (ResultSrcD),
    .PCSrcE       (PCSrcE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .LoadStallCnt (LoadStallCnt),
    .FlushCnt     (FlushCnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rw, input logic [1:0] res);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = res;
  endtask

  // Advance one clock; inputs/checks happen 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    PCSrcE = 1'b0;
    drv(0, 0, 0, 0, 2'b00);

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_flushd", FlushD, 1);
    chk("rst_flushe", FlushE, 1);
    chk("rst_stallf", StallF, 0);
    chk("rst_stalld", StallD, 0);
    chk("rst_fwda",   ForwardAE, 0);
    chk("rst_lscnt",  LoadStallCnt, 0);
    chk("rst_flcnt",  FlushCnt, 0);
    reset = 1'b1;
    #1;
    chk("rel_flushd", FlushD, 0);
    chk("rel_flushe", FlushE, 0);

    // ALU producer immediately followed by consumer -> forward from M
    drv(0, 0, 5, 1, 2'b00);
    tick();
    drv(5, 0, 0, 0, 2'b00);
    #1;
    chk("alu_nostall", StallF, 0);
    tick();
    drv(0, 0, 0, 0, 2'b00);
    #1;
    chk("alu_fwda_mem", ForwardAE, 2'b10);
    chk("alu_fwdb_rf",  ForwardBE, 2'b00);

    // Producer, filler, consumer -> forward from W
    drv(0, 0, 6, 1, 2'b00);
    tick();
    drv(0, 0, 0, 0, 2'b00);
    tick();
    drv(6, 0, 0, 0, 2'b00);
    tick();
    chk("alu_fwda_wb", ForwardAE, 2'b01);

    // Load-use on Rs2
    drv(0, 0, 7, 1, 2'b01);
    tick();
    drv(0, 7, 0, 0, 2'b00);
    #1;
    chk("lu_stallf", StallF, 1);
    chk("lu_stalld", StallD, 1);
    chk("lu_flushe", FlushE, 1);
    chk("lu_flushd", FlushD, 0);
    tick();  // D held by the stall, E bubbled
    chk("lu_one_cycle", StallF, 0);
    chk("lu_cnt", LoadStallCnt, 1);
    tick();
    chk("lu_fwdb_wb", ForwardBE, 2'b01);

    // x0 load never stalls and is never forwarded
    drv(0, 0, 0, 1, 2'b01);
    tick();
    drv(0, 0, 0, 0, 2'b00);
    #1;
    chk("x0_nostall", StallF, 0);
    chk("x0_noflush", FlushE, 0);
    tick();
    chk("x0_fwda", ForwardAE, 2'b00);

    // M and W both write r3 -> M wins
    drv(0, 0, 3, 1, 2'b00);
    tick();
    tick();
    drv(3, 3, 0, 0, 2'b00);
    tick();
    chk("dbl_fwda", ForwardAE, 2'b10);
    chk("dbl_fwdb", ForwardBE, 2'b10);

    // Taken branch squashes the wrong-path consumer in E
    drv(0, 0, 9, 1, 2'b00);
    tick();
    drv(9, 0, 0, 0, 2'b00);
    PCSrcE = 1'b1;
    #1;
    chk("br_flushd", FlushD, 1);
    chk("br_flushe", FlushE, 1);
    chk("br_stallf", StallF, 0);
    tick();
    PCSrcE = 1'b0;
    drv(0, 0, 0, 0, 2'b00);
    #1;
    chk("br_bubble_fwda", ForwardAE, 2'b00);
    chk("br_cnt", FlushCnt, 1);

    // Load-use coinciding with a taken branch
    drv(0, 0, 4, 1, 2'b01);
    tick();
    drv(4, 0, 0, 0, 2'b00);
    PCSrcE = 1'b1;
    #1;
    chk("both_stallf", StallF, 1);
    chk("both_stalld", StallD, 1);
    chk("both_flushd", FlushD, 1);
    chk("both_flushe", FlushE, 1);
    tick();
    PCSrcE = 1'b0;
    #1;
    chk("both_bubble", StallF, 0);
    chk("both_lscnt", LoadStallCnt, 2);
    chk("both_flcnt", FlushCnt, 2);

    // Saturation of the 4-bit flush counter (starts at 2)
    drv(0, 0, 0, 0, 2'b00);
    PCSrcE = 1'b1;
    repeat (12) tick();
    chk("sat_14", FlushCnt, 14);
    repeat (8) tick();
    chk("sat_15", FlushCnt, 15);
    PCSrcE = 1'b0;
    tick();
    chk("sat_hold", FlushCnt, 15);

    // Reset asserted in the middle of a load-use stall
    drv(0, 0, 10, 1, 2'b01);
    tick();
    drv(10, 0, 0, 0, 2'b00);
    #1;
    chk("mid_stall", StallF, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stallf", StallF, 0);
    chk("mid_rst_flushd", FlushD, 1);
    chk("mid_rst_flushe", FlushE, 1);
    chk("mid_rst_lscnt",  LoadStallCnt, 0);
    chk("mid_rst_flcnt",  FlushCnt, 0);
    tick();
    chk("mid_rst_hold", LoadStallCnt, 0);
    reset = 1'b1;
    drv(0, 0, 8, 1, 2'b01);
    tick();
    drv(8, 0, 0, 0, 2'b00);
    #1;
    chk("post_rst_load", StallF, 1);
    tick();
    chk("post_rst_cnt", LoadStallCnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
